// File: rtl/i2c_pkg.sv
// Shared encodings for the I2C target: FSM states and bus-level constants.
package i2c_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_RX_BYTE,
      ST_RX_ACK,
      ST_TX_LOAD,
      ST_TX_BYTE,
      ST_TX_ACK,
      ST_WAIT_STOP
   } state_t;

   localparam logic ACK         = 1'b0;
   localparam logic NACK        = 1'b1;
   localparam logic I2C_RW_READ = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer for one I2C line plus a registered rise/fall detector.
module i2c_line_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic line_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic level_q, level_d;
   logic rise_q,  rise_d;
   logic fall_q,  fall_d;

   // level_q is delayed to line up with the edge strobes it qualifies
   always_comb begin
      sync1_d = line_in;
      sync2_d = sync1_q;
      level_d = sync2_q;
      rise_d  = sync2_q & ~level_q;
      fall_d  = ~sync2_q & level_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b1;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign level = level_q;
   assign rise  = rise_q;
   assign fall  = fall_q;

endmodule

// File: rtl/i2c_slave.sv
// Clock-oversampled 7-bit-address I2C target with multi-byte read/write and
// SCL stretching while local read data is not yet available.
module i2c_slave
   import i2c_pkg::*;
#(
   parameter logic [6:0]  SLAVE_ADDR = 7'h50,
   parameter int unsigned SETUP_CYC  = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   inout  wire        i2c_sda,
   inout  wire        i2c_scl,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ack,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rw,
   output logic       busy
);

   localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC);

   logic sda_lvl, sda_rise, sda_fall;
   logic scl_lvl, scl_rise, scl_fall;
   logic start_det, stop_det;

   state_t     state_q,     state_d;
   logic [2:0] bit_cnt_q,   bit_cnt_d;
   logic       full_q,      full_d;
   logic [7:0] shift_q,     shift_d;
   logic       sda_drv_q,   sda_drv_d;
   logic       scl_hold_q,  scl_hold_d;
   logic       loaded_q,    loaded_d;
   logic [7:0] setup_cnt_q, setup_cnt_d;
   logic [7:0] rx_data_q,   rx_data_d;
   logic       rx_valid_q,  rx_valid_d;
   logic       tx_ack_q,    tx_ack_d;
   logic       rw_q,        rw_d;
   logic       busy_q,      busy_d;

   i2c_line_sync u_sda_sync (
      .clk(clk), .rst_n(rst_n), .line_in(i2c_sda),
      .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
   );

   i2c_line_sync u_scl_sync (
      .clk(clk), .rst_n(rst_n), .line_in(i2c_scl),
      .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
   );

   assign start_det = sda_fall & scl_lvl;
   assign stop_det  = sda_rise & scl_lvl;

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      full_d      = full_q;
      shift_d     = shift_q;
      sda_drv_d   = sda_drv_q;
      scl_hold_d  = scl_hold_q;
      loaded_d    = loaded_q;
      setup_cnt_d = setup_cnt_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      tx_ack_d    = 1'b0;
      rw_d        = rw_q;
      busy_d      = busy_q;

      if (stop_det) begin
         state_d    = ST_IDLE;
         sda_drv_d  = 1'b0;
         scl_hold_d = 1'b0;
         loaded_d   = 1'b0;
         busy_d     = 1'b0;
      end else if (start_det) begin
         state_d    = ST_ADDR;
         bit_cnt_d  = 3'd0;
         full_d     = 1'b0;
         sda_drv_d  = 1'b0;
         scl_hold_d = 1'b0;
         loaded_d   = 1'b0;
      end else begin
         case (state_q)
            ST_ADDR, ST_RX_BYTE: begin
               if (scl_rise) begin
                  shift_d   = {shift_q[6:0], sda_lvl};
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) full_d = 1'b1;
               end else if (scl_fall && full_q) begin
                  full_d = 1'b0;
                  if (state_q == ST_RX_BYTE) begin
                     rx_data_d  = shift_q;
                     rx_valid_d = 1'b1;
                     sda_drv_d  = 1'b1;
                     state_d    = ST_RX_ACK;
                  end else if (shift_q[7:1] == SLAVE_ADDR) begin
                     rw_d      = shift_q[0];
                     sda_drv_d = 1'b1;
                     busy_d    = 1'b1;
                     state_d   = ST_ADDR_ACK;
                  end else begin
                     busy_d  = 1'b0;
                     state_d = ST_WAIT_STOP;
                  end
               end
            end
            ST_ADDR_ACK: begin
               if (scl_fall) begin
                  sda_drv_d = 1'b0;
                  bit_cnt_d = 3'd0;
                  state_d   = (rw_q == I2C_RW_READ) ? ST_TX_LOAD : ST_RX_BYTE;
               end
            end
            ST_RX_ACK: begin
               if (scl_fall) begin
                  sda_drv_d = 1'b0;
                  bit_cnt_d = 3'd0;
                  state_d   = ST_RX_BYTE;
               end
            end
            // SCL is low here; stretch it until local data arrives
            ST_TX_LOAD: begin
               if (loaded_q) begin
                  if (setup_cnt_q <= 8'd1) begin
                     scl_hold_d = 1'b0;
                     loaded_d   = 1'b0;
                     state_d    = ST_TX_BYTE;
                  end else begin
                     setup_cnt_d = setup_cnt_q - 8'd1;
                  end
               end else if (tx_valid) begin
                  shift_d   = tx_data;
                  tx_ack_d  = 1'b1;
                  sda_drv_d = ~tx_data[7];
                  bit_cnt_d = 3'd0;
                  if (scl_hold_q) begin
                     loaded_d    = 1'b1;
                     setup_cnt_d = SETUP_LD;
                  end else begin
                     state_d = ST_TX_BYTE;
                  end
               end else begin
                  scl_hold_d = 1'b1;
               end
            end
            ST_TX_BYTE: begin
               if (scl_fall) begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     sda_drv_d = 1'b0;
                     state_d   = ST_TX_ACK;
                  end else begin
                     shift_d   = shift_q << 1;
                     sda_drv_d = ~shift_q[6];
                  end
               end
            end
            ST_TX_ACK: begin
               if (scl_rise) begin
                  if (sda_lvl == ACK) full_d = 1'b1;
                  else                state_d = ST_WAIT_STOP;
               end else if (scl_fall && full_q) begin
                  full_d  = 1'b0;
                  state_d = ST_TX_LOAD;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= 3'd0;
         full_q      <= 1'b0;
         shift_q     <= 8'd0;
         sda_drv_q   <= 1'b0;
         scl_hold_q  <= 1'b0;
         loaded_q    <= 1'b0;
         setup_cnt_q <= 8'd0;
         rx_data_q   <= 8'd0;
         rx_valid_q  <= 1'b0;
         tx_ack_q    <= 1'b0;
         rw_q        <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         full_q      <= full_d;
         shift_q     <= shift_d;
         sda_drv_q   <= sda_drv_d;
         scl_hold_q  <= scl_hold_d;
         loaded_q    <= loaded_d;
         setup_cnt_q <= setup_cnt_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         tx_ack_q    <= tx_ack_d;
         rw_q        <= rw_d;
         busy_q      <= busy_d;
      end
   end

   assign i2c_sda  = sda_drv_q  ? 1'b0 : 1'bz;
   assign i2c_scl  = scl_hold_q ? 1'b0 : 1'bz;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign tx_ack   = tx_ack_q;
   assign rw       = rw_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed and randomized bench for i2c_slave: a bit-level I2C master drives the
// bus while expected ACKs and data come from address/byte rules kept here.
module tb_i2c_slave;

   localparam int         HALF  = 8;
   localparam logic [6:0] ADDR  = 7'h50;
   localparam int         SETUP = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   wire sda;
   wire scl;
   pullup (sda);
   pullup (scl);
   logic m_sda_low = 1'b0;
   logic m_scl_low = 1'b0;
   assign sda = m_sda_low ? 1'b0 : 1'bz;
   assign scl = m_scl_low ? 1'b0 : 1'bz;

   logic [7:0] tx_data  = 8'd0;
   logic       tx_valid = 1'b0;
   logic       tx_ack;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rw;
   logic       busy;

   i2c_slave #(.SLAVE_ADDR(ADDR), .SETUP_CYC(SETUP)) dut (
      .clk(clk), .rst_n(rst_n), .i2c_sda(sda), .i2c_scl(scl),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ack(tx_ack),
      .rx_data(rx_data), .rx_valid(rx_valid), .rw(rw), .busy(busy)
   );

   int         n_tests = 0;
   int         n_fail  = 0;
   int         tx_ack_cnt = 0;
   logic [7:0] tx_q[$];
   logic [7:0] rx_obs[$];
   logic [7:0] rx_exp[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Local-side model: present queued read bytes, consume one per tx_ack
   always @(negedge clk) begin
      if (tx_ack && tx_q.size() > 0) void'(tx_q.pop_front());
      if (tx_q.size() > 0) begin
         tx_valid = 1'b1;
         tx_data  = tx_q[0];
      end else begin
         tx_valid = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (rx_valid) begin
         rx_obs.push_back(rx_data);
         check("rx_valid_with_ack_drive", sda, 1'b0);
      end
      if (tx_ack) tx_ack_cnt++;
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic wclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic scl_up();
      int k;
      m_scl_low = 1'b0;
      k = 0;
      while (scl !== 1'b1 && k < 4000) begin
         wclk(1);
         k++;
      end
      if (k >= 4000) check("scl_release_timeout", scl, 1'b1);
   endtask

   task automatic bus_start();
      m_sda_low = 1'b0;
      wclk(HALF);
      scl_up();
      wclk(HALF);
      m_sda_low = 1'b1;
      wclk(HALF);
      m_scl_low = 1'b1;
      wclk(2);
   endtask

   task automatic bus_stop();
      m_sda_low = 1'b1;
      wclk(HALF);
      scl_up();
      wclk(HALF);
      m_sda_low = 1'b0;
      wclk(HALF);
   endtask

   task automatic write_bit(input logic b);
      m_sda_low = ~b;
      wclk(HALF);
      scl_up();
      wclk(HALF);
      m_scl_low = 1'b1;
      wclk(2);
   endtask

   task automatic read_bit(output logic b);
      m_sda_low = 1'b0;
      wclk(HALF);
      scl_up();
      wclk(HALF / 2);
      b = sda;
      wclk(HALF / 2);
      m_scl_low = 1'b1;
      wclk(2);
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) write_bit(d[i]);
      read_bit(ack);
   endtask

   task automatic read_byte(output logic [7:0] d, input logic master_ack);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         read_bit(b);
         d[i] = b;
      end
      write_bit(master_ack);
   endtask

   task automatic check_rx(input string tag);
      check({tag, "_count"}, rx_obs.size(), rx_exp.size());
      for (int i = 0; i < rx_exp.size() && i < rx_obs.size(); i++)
         check({tag, "_byte"}, rx_obs[i], rx_exp[i]);
      rx_obs.delete();
      rx_exp.delete();
   endtask

   initial begin
      logic       ack;
      logic       b;
      logic [7:0] d;
      logic [7:0] exp_b[$];
      int         k;
      int         base;

      // reset values
      wclk(3);
      check("rst_sda", sda, 1'b1);
      check("rst_scl", scl, 1'b1);
      check("rst_rx_data", rx_data, 8'h00);
      check("rst_rx_valid", rx_valid, 1'b0);
      check("rst_tx_ack", tx_ack, 1'b0);
      check("rst_rw", rw, 1'b0);
      check("rst_busy", busy, 1'b0);
      rst_n = 1'b1;
      wclk(4);

      // write to matching address
      bus_start();
      write_byte({ADDR, 1'b0}, ack);
      check("wr_addr_ack", ack, 1'b0);
      check("wr_rw", rw, 1'b0);
      foreach (exp_b[i]) exp_b.delete(i);
      rx_exp.push_back(8'hA5);
      rx_exp.push_back(8'h3C);
      write_byte(8'hA5, ack);
      check("wr_d0_ack", ack, 1'b0);
      write_byte(8'h3C, ack);
      check("wr_d1_ack", ack, 1'b0);
      check("wr_busy_before_stop", busy, 1'b1);
      bus_stop();
      check("wr_busy_after_stop", busy, 1'b0);
      check_rx("wr");

      // address mismatch
      bus_start();
      write_byte({7'h51, 1'b0}, ack);
      check("mm_addr_nack", ack, 1'b1);
      check("mm_busy", busy, 1'b0);
      write_byte(8'h55, ack);
      check("mm_data_nack", ack, 1'b1);
      bus_stop();
      check_rx("mm");

      // read with stretch
      base = tx_ack_cnt;
      bus_start();
      write_byte({ADDR, 1'b1}, ack);
      check("st_addr_ack", ack, 1'b0);
      check("st_rw", rw, 1'b1);
      m_sda_low = 1'b0;
      wclk(HALF);
      m_scl_low = 1'b0;
      wclk(40);
      check("st_scl_held", scl, 1'b0);
      tx_q.push_back(8'hC3);
      k = 0;
      while (tx_ack !== 1'b1 && k < 100) begin
         wclk(1);
         k++;
      end
      check("st_tx_ack_seen", tx_ack, 1'b1);
      k = 0;
      while (scl !== 1'b1 && k < 100) begin
         wclk(1);
         k++;
      end
      check("st_setup_cycles", k, SETUP);
      read_byte(d, 1'b1);
      check("st_data", d, 8'hC3);
      bus_stop();
      check("st_tx_ack_count", tx_ack_cnt - base, 1);
      check("st_busy", busy, 1'b0);

      // multi-byte read, NACK on the last
      base = tx_ack_cnt;
      tx_q.push_back(8'h11);
      tx_q.push_back(8'h22);
      bus_start();
      write_byte({ADDR, 1'b1}, ack);
      check("mr_addr_ack", ack, 1'b0);
      read_byte(d, 1'b0);
      check("mr_d0", d, 8'h11);
      read_byte(d, 1'b1);
      check("mr_d1", d, 8'h22);
      wclk(4);
      check("mr_sda_released", sda, 1'b1);
      check("mr_busy_wait_stop", busy, 1'b1);
      bus_stop();
      check("mr_tx_ack_count", tx_ack_cnt - base, 2);
      check("mr_busy_after_stop", busy, 1'b0);

      // repeated START: write then read
      bus_start();
      write_byte({ADDR, 1'b0}, ack);
      check("rs_wr_ack", ack, 1'b0);
      check("rs_rw0", rw, 1'b0);
      rx_exp.push_back(8'h07);
      write_byte(8'h07, ack);
      check("rs_d_ack", ack, 1'b0);
      bus_start();
      check("rs_busy_kept", busy, 1'b1);
      tx_q.push_back(8'h9E);
      write_byte({ADDR, 1'b1}, ack);
      check("rs_rd_ack", ack, 1'b0);
      check("rs_rw1", rw, 1'b1);
      read_byte(d, 1'b1);
      check("rs_rd_data", d, 8'h9E);
      bus_stop();
      check_rx("rs");

      // reset during 4th data bit of a read (bit4 of 0xE5 is 0)
      tx_q.push_back(8'hE5);
      bus_start();
      write_byte({ADDR, 1'b1}, ack);
      check("rr_addr_ack", ack, 1'b0);
      for (int i = 0; i < 3; i++) read_bit(b);
      m_sda_low = 1'b0;
      wclk(HALF);
      scl_up();
      wclk(2);
      check("rr_sda_driven", sda, 1'b0);
      rst_n = 1'b0;
      #1;
      check("rr_sda_released", sda, 1'b1);
      check("rr_scl_released", scl, 1'b1);
      check("rr_rx_data", rx_data, 8'h00);
      check("rr_rw", rw, 1'b0);
      check("rr_busy", busy, 1'b0);
      check("rr_tx_ack", tx_ack, 1'b0);
      wclk(3);
      rst_n = 1'b1;
      wclk(HALF);
      bus_start();
      write_byte({ADDR, 1'b0}, ack);
      check("rr_after_ack", ack, 1'b0);
      rx_exp.push_back(8'h6B);
      write_byte(8'h6B, ack);
      check("rr_after_d_ack", ack, 1'b0);
      bus_stop();
      check_rx("rr");

      // randomized transactions against the address/data rules
      for (int t = 0; t < 10; t++) begin
         logic [6:0] a7;
         logic       rwb;
         logic       match;
         int         len;
         a7    = ($urandom_range(0, 1) == 1) ? ADDR : 7'($urandom);
         rwb   = 1'($urandom_range(0, 1));
         len   = $urandom_range(1, 3);
         match = (a7 == ADDR);
         exp_b.delete();
         if (match && rwb)
            for (int i = 0; i < len; i++) begin
               exp_b.push_back(8'($urandom));
               tx_q.push_back(exp_b[i]);
            end
         base = tx_ack_cnt;
         bus_start();
         write_byte({a7, rwb}, ack);
         check("rnd_addr_ack", ack, match ? 1'b0 : 1'b1);
         if (match && !rwb) begin
            for (int i = 0; i < len; i++) begin
               d = 8'($urandom);
               rx_exp.push_back(d);
               write_byte(d, ack);
               check("rnd_wr_ack", ack, 1'b0);
            end
         end else if (match) begin
            for (int i = 0; i < len; i++) begin
               read_byte(d, (i == len - 1) ? 1'b1 : 1'b0);
               check("rnd_rd_data", d, exp_b[i]);
            end
         end
         bus_stop();
         check("rnd_busy", busy, 1'b0);
         check("rnd_tx_ack_count", tx_ack_cnt - base, (match && rwb) ? len : 0);
         check_rx("rnd_rx");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
